// File: rtl/alu_md.sv
// Execute-stage ALU with iterative radix-2 unsigned multiply/divide; valid/ready in, valid pulse out.
// Latency: 1 cycle for simple ops, XLEN+2 for MUL/MULHU/DIVU/REMU; ready_o low while an iterative op runs, no output backpressure.
module alu_md #(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 5,
    parameter int LUI_SH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       alu_op_i,
    input  logic [XLEN-1:0]  alu_a_i,
    input  logic [XLEN-1:0]  alu_b_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output logic [XLEN-1:0]  alu_result_o,
    output logic [TAG_W-1:0] tag_o
);
    localparam int SHAMT_W = $clog2(XLEN);
    localparam int CNT_W   = $clog2(XLEN) + 1;

    localparam logic [3:0] OP_ADD = 4'd0,  OP_AND = 4'd1,  OP_SLL = 4'd2,  OP_SRL = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4,  OP_XOR = 4'd5,  OP_ONE = 4'd6,  OP_ZERO = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8,  OP_LUI = 4'd9,  OP_SUB = 4'd10, OP_MUL = 4'd11;
    localparam logic [3:0] OP_MULHU = 4'd12, OP_DIVU = 4'd13, OP_REMU = 4'd14;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic [TAG_W-1:0]  tag_lat_q, tag_lat_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [TAG_W-1:0]  tag_q, tag_d;

    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    res_sc;
    logic               accept, is_multi_i, is_mul_i, busy_mul;
    logic [XLEN:0]      mul_sum, div_sh;
    logic [XLEN-1:0]    div_diff;
    logic               div_ge;

    assign ready_o      = (state_q == IDLE) && !rst;
    assign valid_o      = valid_q;
    assign alu_result_o = result_q;
    assign tag_o        = tag_q;

    assign accept     = valid_i && ready_o;
    assign shamt      = alu_b_i[SHAMT_W-1:0];
    assign is_mul_i   = (alu_op_i == OP_MUL) || (alu_op_i == OP_MULHU);
    assign is_multi_i = is_mul_i || (alu_op_i == OP_DIVU) || (alu_op_i == OP_REMU);
    assign busy_mul   = (op_q == OP_MUL) || (op_q == OP_MULHU);

    // Multiply: hi accumulates, lo holds the remaining multiplier bits and collects the low product.
    assign mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : {XLEN{1'b0}})};
    // Divide: hi is the partial remainder, lo shifts the dividend out and the quotient in.
    assign div_sh   = {hi_q, lo_q[XLEN-1]};
    assign div_ge   = div_sh >= {1'b0, opnd_q};
    assign div_diff = div_sh[XLEN-1:0] - opnd_q;

    always_comb begin
        res_sc = '0;
        case (alu_op_i)
            OP_ADD:  res_sc = alu_a_i + alu_b_i;
            OP_AND:  res_sc = alu_a_i & alu_b_i;
            OP_SLL:  res_sc = alu_a_i << shamt;
            OP_SRL:  res_sc = alu_a_i >> shamt;
            OP_OR:   res_sc = alu_a_i | alu_b_i;
            OP_XOR:  res_sc = alu_a_i ^ alu_b_i;
            OP_ONE:  res_sc = {{(XLEN-1){1'b0}}, 1'b1};
            OP_ZERO: res_sc = '0;
            OP_SRA:  res_sc = $unsigned($signed(alu_a_i) >>> shamt);
            OP_LUI:  res_sc = alu_b_i << LUI_SH;
            OP_SUB:  res_sc = alu_a_i - alu_b_i;
            default: res_sc = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        tag_lat_d = tag_lat_q;
        valid_d   = 1'b0;
        result_d  = result_q;
        tag_d     = tag_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_multi_i) begin
                        op_d      = alu_op_i;
                        tag_lat_d = tag_i;
                        cnt_d     = CNT_W'(XLEN);
                        hi_d      = '0;
                        lo_d      = is_mul_i ? alu_b_i : alu_a_i;
                        opnd_d    = is_mul_i ? alu_a_i : alu_b_i;
                        state_d   = BUSY;
                    end else begin
                        result_d = res_sc;
                        tag_d    = tag_i;
                        valid_d  = 1'b1;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (busy_mul) begin
                    hi_d = mul_sum[XLEN:1];
                    lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                end else begin
                    hi_d = div_ge ? div_diff : div_sh[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], div_ge};
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                result_d = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? lo_q : hi_q;
                tag_d    = tag_lat_q;
                valid_d  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            tag_lat_q <= '0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            tag_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opnd_q    <= opnd_d;
            tag_lat_q <= tag_lat_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            tag_q     <= tag_d;
        end
    end
endmodule

// File: tb/tb_alu_md.sv
// Directed bench for alu_md: XLEN=32 and XLEN=8 instances share one stimulus path selected by sel8.
module tb_alu_md;
    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic        sel8;
    logic [3:0]  op_i;
    logic [31:0] a_i, b_i;
    logic [4:0]  tg_i;

    logic        rdy32, v32, rdy8, v8;
    logic [31:0] r32;
    logic [7:0]  r8;
    logic [4:0]  t32, t8;

    logic        o_vld, o_rdy;
    logic [31:0] o_res;
    logic [4:0]  o_tag;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_md dut32 (
        .clk(clk), .rst(rst), .valid_i(vld && !sel8), .ready_o(rdy32),
        .alu_op_i(op_i), .alu_a_i(a_i), .alu_b_i(b_i), .tag_i(tg_i),
        .valid_o(v32), .alu_result_o(r32), .tag_o(t32)
    );

    alu_md #(.XLEN(8)) dut8 (
        .clk(clk), .rst(rst), .valid_i(vld && sel8), .ready_o(rdy8),
        .alu_op_i(op_i), .alu_a_i(a_i[7:0]), .alu_b_i(b_i[7:0]), .tag_i(tg_i),
        .valid_o(v8), .alu_result_o(r8), .tag_o(t8)
    );

    assign o_vld = sel8 ? v8 : v32;
    assign o_rdy = sel8 ? rdy8 : rdy32;
    assign o_res = sel8 ? {24'h0, r8} : r32;
    assign o_tag = sel8 ? t8 : t32;

    typedef struct {
        bit          s8;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic run_multi(input bit s8, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] tg,
                             input logic [31:0] exp, input string nm);
        int  lat;
        bit  rdy_bad;
        int  want;
        want = s8 ? 10 : 34;
        sel8 = s8; op_i = op; a_i = a; b_i = b; tg_i = tg; vld = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0; a_i = ~a; b_i = ~b; tg_i = ~tg;
        lat = 0; rdy_bad = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (o_vld) begin
                lat = k;
                break;
            end
            if (o_rdy) rdy_bad = 1'b1;
            @(posedge clk); #1;
        end
        chk({nm, " latency"}, 64'(lat), 64'(want));
        chk({nm, " result"}, 64'(o_res), 64'(exp));
        chk({nm, " tag"}, 64'(o_tag), 64'(tg));
        chk({nm, " ready_low_while_busy"}, 64'(rdy_bad), 64'd0);
        chk({nm, " ready_in_valid_cycle"}, 64'(o_rdy), 64'd1);
        @(posedge clk); #1;
        chk({nm, " valid_single_pulse"}, 64'(o_vld), 64'd0);
    endtask

    vec_t sc[14];
    vec_t mc[11];

    initial begin
        int lat;
        int extra;

        sc[0]  = '{0, 4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        sc[1]  = '{0, 4'd8,  32'h80000000, 32'h00000024, 32'hF8000000};
        sc[2]  = '{0, 4'd9,  32'h0000BEEF, 32'h00012345, 32'h12345000};
        sc[3]  = '{0, 4'd10, 32'h00000005, 32'h00000007, 32'hFFFFFFFE};
        sc[4]  = '{0, 4'd1,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0};
        sc[5]  = '{0, 4'd4,  32'h0F000000, 32'h000000F0, 32'h0F0000F0};
        sc[6]  = '{0, 4'd5,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F};
        sc[7]  = '{0, 4'd2,  32'h00000001, 32'h00000021, 32'h00000002};
        sc[8]  = '{0, 4'd3,  32'h80000000, 32'h0000001F, 32'h00000001};
        sc[9]  = '{0, 4'd6,  32'h12345678, 32'h9ABCDEF0, 32'h00000001};
        sc[10] = '{0, 4'd7,  32'h12345678, 32'h9ABCDEF0, 32'h00000000};
        sc[11] = '{0, 4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        sc[12] = '{0, 4'd8,  32'h40000000, 32'h00000004, 32'h04000000};
        sc[13] = '{1, 4'd2,  32'h00000001, 32'h0000000B, 32'h00000008};

        mc[0]  = '{0, 4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        mc[1]  = '{0, 4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        mc[2]  = '{0, 4'd13, 32'd100,      32'd7,        32'd14};
        mc[3]  = '{0, 4'd14, 32'd100,      32'd7,        32'd2};
        mc[4]  = '{0, 4'd13, 32'd5,        32'd0,        32'hFFFFFFFF};
        mc[5]  = '{0, 4'd14, 32'd5,        32'd0,        32'd5};
        mc[6]  = '{0, 4'd11, 32'h12345678, 32'h00000010, 32'h23456780};
        mc[7]  = '{0, 4'd12, 32'h12345678, 32'h00000010, 32'h00000001};
        mc[8]  = '{1, 4'd13, 32'h000000FF, 32'h00000010, 32'h0000000F};
        mc[9]  = '{1, 4'd14, 32'h000000FF, 32'h00000010, 32'h0000000F};
        mc[10] = '{1, 4'd11, 32'h0000000F, 32'h00000011, 32'h000000FF};

        rst = 1'b1; vld = 1'b0; sel8 = 1'b0; op_i = '0; a_i = '0; b_i = '0; tg_i = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset valid_o", 64'(o_vld), 64'd0);
        chk("reset result", 64'(o_res), 64'd0);
        chk("reset tag", 64'(o_tag), 64'd0);
        chk("reset ready_o", 64'(o_rdy), 64'd0);
        rst = 1'b0; #1;
        chk("ready after reset", 64'(o_rdy), 64'd1);

        // Single-cycle ops issued back to back, one result per cycle.
        for (int i = 0; i < 14; i++) begin
            sel8 = sc[i].s8; op_i = sc[i].op; a_i = sc[i].a; b_i = sc[i].b;
            tg_i = 5'(i + 3); vld = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("sc%0d valid", i), 64'(o_vld), 64'd1);
            chk($sformatf("sc%0d result", i), 64'(o_res), 64'(sc[i].exp));
            chk($sformatf("sc%0d tag", i), 64'(o_tag), 64'(i + 3));
        end
        vld = 1'b0;
        @(posedge clk); #1;
        chk("sc idle valid", 64'(o_vld), 64'd0);

        for (int i = 0; i < 11; i++) begin
            run_multi(mc[i].s8, mc[i].op, mc[i].a, mc[i].b, 5'(20 + i), mc[i].exp,
                      $sformatf("mc%0d", i));
        end

        // Request held during a divide is only taken once the divide completes.
        sel8 = 1'b0; op_i = 4'd13; a_i = 32'd100; b_i = 32'd7; tg_i = 5'd7; vld = 1'b1;
        @(posedge clk); #1;
        op_i = 4'd0; a_i = 32'd2; b_i = 32'd3; tg_i = 5'd9;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            if (o_vld) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        chk("hold latency", 64'(lat), 64'd34);
        chk("hold divu result", 64'(o_res), 64'd14);
        chk("hold divu tag", 64'(o_tag), 64'd7);
        @(posedge clk); #1;
        vld = 1'b0;
        chk("hold add valid", 64'(o_vld), 64'd1);
        chk("hold add result", 64'(o_res), 64'd5);
        chk("hold add tag", 64'(o_tag), 64'd9);
        @(posedge clk); #1;
        chk("hold add single pulse", 64'(o_vld), 64'd0);

        // Reset lands on the 10th iteration edge of a multiply.
        op_i = 4'd11; a_i = 32'hFFFFFFFF; b_i = 32'd3; tg_i = 5'd11; vld = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1; #1;
        chk("mid rst ready low", 64'(o_rdy), 64'd0);
        @(posedge clk); #1;
        chk("mid rst valid", 64'(o_vld), 64'd0);
        chk("mid rst result", 64'(o_res), 64'd0);
        chk("mid rst tag", 64'(o_tag), 64'd0);
        chk("mid rst ready", 64'(o_rdy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; #1;
        chk("post rst ready", 64'(o_rdy), 64'd1);
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            if (o_vld) extra++;
            @(posedge clk); #1;
        end
        chk("abandoned op no valid", 64'(extra), 64'd0);
        op_i = 4'd0; a_i = 32'd2; b_i = 32'd3; tg_i = 5'd12; vld = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0;
        chk("post rst add valid", 64'(o_vld), 64'd1);
        chk("post rst add result", 64'(o_res), 64'd5);
        chk("post rst add tag", 64'(o_tag), 64'd12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
